// File: rtl/alu_resp_checker.sv
// alu_resp_checker: response checker on the result side of an 8-bit style ALU.
// Each counted vector compares alu_out against a golden model of the ALU.
// It counts vectors and mismatches and records the select of the first mismatch.
// Pass/fail is reported through a start/done handshake.
//
// Optional feature: define ALU_RESP_CHECKER_SIG_EN to build a 16-bit MISR over
// the counted results. Without the macro, sig is tied to 16'h0000.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             begins a run (honoured only in IDLE)
//   vld               alu_a/alu_b/alu_sel/alu_out form a vector this cycle
//   alu_a, alu_b      ALU operands
//   alu_sel           ALU select
//   alu_out           ALU result under check
//   busy              high while in RUN
//   done              one-cycle pulse when a run completes
//   pass              last completed run had no mismatches
//   err_cnt, vec_cnt  mismatch and vector counters of the current/last run
//   first_err_valid   a mismatch has been captured
//   first_err_sel     alu_sel of the first mismatch
//   sig               result signature (0 when the MISR is not built)
module alu_resp_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_VEC = 8,
  parameter int unsigned CW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    vec_cnt,
  output logic             first_err_valid,
  output logic [2:0]       first_err_sel,
  output logic [15:0]      sig
);

  localparam logic [CW-1:0] ERR_MAX  = '1;
  localparam logic [CW-1:0] LAST_VEC = CW'(NUM_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] golden;
  logic             mismatch;
  logic [CW-1:0]    err_next;

  // Golden ALU model, all results modulo 2^WIDTH
  always_comb begin
    golden = '0;
    case (alu_sel)
      3'd0:    golden = alu_a + alu_b;
      3'd1:    golden = alu_a - alu_b;
      3'd2:    golden = alu_a & alu_b;
      3'd3:    golden = alu_a | alu_b;
      3'd4:    golden = alu_a ^ alu_b;
      3'd5:    golden = ~alu_a;
      3'd6:    golden = {alu_a[WIDTH-2:0], 1'b0};
      3'd7:    golden = {1'b0, alu_a[WIDTH-1:1]};
      default: golden = '0;
    endcase
  end

  // Saturating error count including the vector on the inputs now
  always_comb begin
    mismatch = (golden != alu_out);
    err_next = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_next = err_cnt + CW'(1);
    end
  end

  // Run control, counters and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      vec_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_sel   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_cnt         <= '0;
            vec_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_sel   <= 3'd0;
          end
        end
        RUN: begin
          if (vld) begin
            vec_cnt <= vec_cnt + CW'(1);
            err_cnt <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_sel   <= alu_sel;
            end
            // The final vector is still checked; pass reflects it
            if (vec_cnt == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_RESP_CHECKER_SIG_EN
  // MISR, polynomial x^16+x^15+x^13+x^4+1, folded with each counted result
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if ((state == IDLE) && start) begin
      sig <= 16'hFFFF;
    end else if ((state == RUN) && vld) begin
      sig <= {sig[14:0], sig[15] ^ sig[14] ^ sig[12] ^ sig[3]} ^ 16'(alu_out);
    end
  end
`else
  assign sig = 16'h0000;
`endif

endmodule
